jtag_ahb_ap_engine: RTL and testbench

- Parametrised AHB-Lite master access-port engine behind the JTAG AHB instruction; successor to the fixed 32-bit AP shift format.
- Consumes one decoded AP command per DR update (already synchronised into the system clock domain) and performs at most one single AHB-Lite transfer.
- Adds generic address/data width, 64-bit transfers, size-scaled auto-increment, sticky error/overrun status and a capture word for the next DR scan.

---
 rtl/jtag_types_pkg.sv | 44 ++++
 rtl/jtag_ap_addr_inc.sv | 20 ++
 rtl/jtag_ahb_ap_engine.sv | 146 ++++++++++++++
 tb/tb_jtag_ahb_ap_engine.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_types_pkg.sv
// Shared JTAG/AP types: widths, AHB encodings, AP command/status bundles.
// Used by jtag_ahb_ap_engine and jtag_ap_addr_inc.
package jtag_types_pkg;

  localparam int AP_ADDR_WIDTH = 32;
  localparam int AP_DATA_WIDTH = 32;

  typedef enum logic {
    ADDRESS = 1'b0,
    DATA    = 1'b1
  } regselect_t;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } r_w_t;

  typedef enum logic [1:0] {
    BYTE     = 2'b00,
    HALFWORD = 2'b01,
    WORD     = 2'b10,
    DWORD    = 2'b11
  } hsize_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    NONSEQ = 2'b10
  } htrans_t;

  typedef struct packed {
    logic [AP_DATA_WIDTH-1:0] data;
    regselect_t               regselect;
    hsize_t                   size;
    logic                     addrinc;
    r_w_t                     r_w;
  } ap_cmd_t;

  typedef struct packed {
    logic busy;
    logic err;
    logic ovr;
  } ap_status_t;

endpackage

// File: rtl/jtag_ap_addr_inc.sv
// Size-scaled wrapping address incrementer and alignment check.
// Ports: addr/size in; addr_next = addr + (1<<size) mod 2^W, aligned out.
module jtag_ap_addr_inc
  import jtag_types_pkg::*;
#(
  parameter int ADDR_WIDTH = AP_ADDR_WIDTH
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  hsize_t                size,
  output logic [ADDR_WIDTH-1:0] addr_next,
  output logic                  aligned
);

  logic [ADDR_WIDTH-1:0] step;

  assign step      = ADDR_WIDTH'(1) << size;
  assign addr_next = addr + step;
  assign aligned   = ((addr & (step - ADDR_WIDTH'(1))) == '0);

endmodule

// File: rtl/jtag_ahb_ap_engine.sv
// JTAG AP engine: one AP command -> at most one AHB-Lite SINGLE transfer.
// Ports: CLK/nRST, cmd_* command, status_clr, cap_word/busy, AHB master.
// Optional: JTAG_AP_ALIGN_CHECK_EN rejects misaligned DATA commands.
module jtag_ahb_ap_engine
  import jtag_types_pkg::*;
#(
  parameter int ADDR_WIDTH = AP_ADDR_WIDTH,
  parameter int DATA_WIDTH = AP_DATA_WIDTH
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  cmd_valid,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  input  logic                  cmd_regsel,
  input  logic [1:0]            cmd_size,
  input  logic                  cmd_addrinc,
  input  logic                  cmd_rw,
  input  logic                  status_clr,
  output logic [DATA_WIDTH+2:0] cap_word,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] HADDR,
  output logic [1:0]            HTRANS,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [DATA_WIDTH-1:0] HWDATA,
  input  logic [DATA_WIDTH-1:0] HRDATA,
  input  logic                  HREADY,
  input  logic                  HRESP
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR_PH,
    ST_DATA_PH
  } state_t;

  localparam int LW =
    (ADDR_WIDTH < DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;

  state_t                state;
  ap_status_t            st;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] addr_next;
  logic [ADDR_WIDTH-1:0] addr_load;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  inc_q;
  logic                  aligned;
  logic                  misalign;
  logic                  size_bad;
  logic                  is_data;
  logic                  bad;
  logic                  err_set;
  logic                  ovr_set;
  hsize_t                inc_size;

  // Alignment is judged on the incoming size; the increment
  // later uses the size already on HSIZE.
  assign inc_size = (state == ST_IDLE) ? hsize_t'(cmd_size)
                                       : hsize_t'(HSIZE[1:0]);

  jtag_ap_addr_inc #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_inc (
    .addr      (addr_q),
    .size      (inc_size),
    .addr_next (addr_next),
    .aligned   (aligned)
  );

`ifdef JTAG_AP_ALIGN_CHECK_EN
  assign misalign = ~aligned;
`else
  logic unused_aligned;
  assign unused_aligned = aligned;
  assign misalign = 1'b0;
`endif

  assign addr_load = ADDR_WIDTH'(cmd_data[LW-1:0]);
  assign size_bad  = (DATA_WIDTH == 32) &&
                     (cmd_size == DWORD);
  assign is_data   = cmd_valid && (cmd_regsel == DATA);
  assign bad       = size_bad | misalign;
  assign ovr_set   = cmd_valid & st.busy;
  assign err_set   = (state == ST_IDLE && is_data && bad) ||
                     (state == ST_DATA_PH && HRESP);

  assign busy     = st.busy;
  assign cap_word = {rdata_q, st};
  assign HBURST   = 3'b000;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= ST_IDLE;
      st      <= '0;
      addr_q  <= '0;
      rdata_q <= '0;
      wdata_q <= '0;
      inc_q   <= 1'b0;
      HADDR   <= '0;
      HTRANS  <= IDLE;
      HWRITE  <= 1'b0;
      HSIZE   <= '0;
      HWDATA  <= '0;
    end else begin
      st.err <= err_set | (st.err & ~status_clr);
      st.ovr <= ovr_set | (st.ovr & ~status_clr);
      unique case (state)
        ST_IDLE: begin
          if (cmd_valid && cmd_regsel == ADDRESS) begin
            addr_q <= addr_load;
          end else if (is_data && !bad) begin
            state   <= ST_ADDR_PH;
            st.busy <= 1'b1;
            HTRANS  <= NONSEQ;
            HADDR   <= addr_q;
            HWRITE  <= cmd_rw;
            HSIZE   <= {1'b0, cmd_size};
            wdata_q <= cmd_data;
            inc_q   <= cmd_addrinc;
          end
        end
        ST_ADDR_PH: begin
          if (HREADY) begin
            state  <= ST_DATA_PH;
            HTRANS <= IDLE;
            HWDATA <= wdata_q;
          end
        end
        ST_DATA_PH: begin
          if (HREADY) begin
            state   <= ST_IDLE;
            st.busy <= 1'b0;
            if (!HRESP) begin
              if (!HWRITE) rdata_q <= HRDATA;
              if (inc_q) addr_q <= addr_next;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_ahb_ap_engine.sv
// Self-checking bench for jtag_ahb_ap_engine (32/32 build).
// Directed steps plus randomized commands against a reference model.
module tb_jtag_ahb_ap_engine;

  logic        CLK;
  logic        nRST;
  logic        cmd_valid;
  logic [31:0] cmd_data;
  logic        cmd_regsel;
  logic [1:0]  cmd_size;
  logic        cmd_addrinc;
  logic        cmd_rw;
  logic        status_clr;
  logic [34:0] cap_word;
  logic        busy;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  int checks = 0;
  int failures = 0;

  logic [31:0] m_addr;
  logic [31:0] m_rdata;
  logic        m_err;
  logic        m_ovr;

  jtag_ahb_ap_engine #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32)
  ) dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .cmd_valid   (cmd_valid),
    .cmd_data    (cmd_data),
    .cmd_regsel  (cmd_regsel),
    .cmd_size    (cmd_size),
    .cmd_addrinc (cmd_addrinc),
    .cmd_rw      (cmd_rw),
    .status_clr  (status_clr),
    .cap_word    (cap_word),
    .busy        (busy),
    .HADDR       (HADDR),
    .HTRANS      (HTRANS),
    .HWRITE      (HWRITE),
    .HSIZE       (HSIZE),
    .HBURST      (HBURST),
    .HWDATA      (HWDATA),
    .HRDATA      (HRDATA),
    .HREADY      (HREADY),
    .HRESP       (HRESP)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_cap(input string tag, input logic b);
    check(tag, 64'(cap_word),
          64'({m_rdata, b, m_err, m_ovr}));
  endtask

  task automatic addr_cmd(input logic [31:0] a);
    cmd_valid  = 1'b1;
    cmd_regsel = 1'b0;
    cmd_data   = a;
    @(negedge CLK);
    cmd_valid = 1'b0;
    cmd_data  = $urandom;
    m_addr    = a;
    check("addr_htrans", 64'(HTRANS), 64'(0));
    check_cap("addr_cap", 1'b0);
  endtask

  task automatic clr_status();
    status_clr = 1'b1;
    @(negedge CLK);
    status_clr = 1'b0;
    m_err = 1'b0;
    m_ovr = 1'b0;
    check_cap("clr_cap", 1'b0);
  endtask

  task automatic data_cmd(input logic rw, input logic [1:0] sz,
                          input logic inc, input logic [31:0] wd,
                          input int waits, input logic eresp,
                          input logic [31:0] rd, input logic poke);
    logic        rej;
    logic [31:0] step;
    step = 32'd1 << sz;
    rej  = (sz == 2'd3);
`ifdef JTAG_AP_ALIGN_CHECK_EN
    if ((m_addr % step) != 0) rej = 1'b1;
`endif
    cmd_valid   = 1'b1;
    cmd_regsel  = 1'b1;
    cmd_rw      = rw;
    cmd_size    = sz;
    cmd_addrinc = inc;
    cmd_data    = wd;
    HREADY      = 1'b1;
    HRESP       = 1'b0;
    @(negedge CLK);
    cmd_valid = 1'b0;
    cmd_data  = $urandom;
    if (rej) begin
      m_err = 1'b1;
      check("rej_htrans", 64'(HTRANS), 64'(0));
      check_cap("rej_cap", 1'b0);
      return;
    end
    check("a_htrans", 64'(HTRANS), 64'(2'b10));
    check("a_haddr", 64'(HADDR), 64'(m_addr));
    check("a_hwrite", 64'(HWRITE), 64'(rw));
    check("a_hsize", 64'(HSIZE), 64'({1'b0, sz}));
    check("a_hburst", 64'(HBURST), 64'(0));
    check_cap("a_cap", 1'b1);
    if (poke) begin
      cmd_valid  = 1'b1;
      cmd_regsel = 1'b0;
      m_ovr      = 1'b1;
    end
    for (int i = 0; i < waits; i++) begin
      HREADY = 1'b0;
      @(negedge CLK);
      cmd_valid = 1'b0;
      check("w_htrans", 64'(HTRANS), 64'(2'b10));
      check("w_haddr", 64'(HADDR), 64'(m_addr));
    end
    HREADY = 1'b1;
    @(negedge CLK);
    cmd_valid = 1'b0;
    check("d_htrans", 64'(HTRANS), 64'(0));
    check("d_hwdata", 64'(HWDATA), 64'(wd));
    check("d_busy", 64'(busy), 64'(1));
    if (eresp) begin
      HREADY = 1'b0;
      HRESP  = 1'b1;
      @(negedge CLK);
      m_err = 1'b1;
      check_cap("e1_cap", 1'b1);
      HREADY = 1'b1;
      @(negedge CLK);
      HRESP = 1'b0;
    end else begin
      HRDATA = rd;
      @(negedge CLK);
      HRDATA = $urandom;
      if (!rw) m_rdata = rd;
      if (inc) m_addr = m_addr + step;
    end
    check("f_htrans", 64'(HTRANS), 64'(0));
    check_cap("f_cap", 1'b0);
  endtask

  initial begin
    nRST        = 1'b0;
    cmd_valid   = 1'b0;
    cmd_data    = '0;
    cmd_regsel  = 1'b0;
    cmd_size    = '0;
    cmd_addrinc = 1'b0;
    cmd_rw      = 1'b0;
    status_clr  = 1'b0;
    HRDATA      = '0;
    HREADY      = 1'b1;
    HRESP       = 1'b0;
    m_addr  = '0;
    m_rdata = '0;
    m_err   = 1'b0;
    m_ovr   = 1'b0;
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
    check("rst_htrans", 64'(HTRANS), 64'(0));
    check("rst_haddr", 64'(HADDR), 64'(0));
    check("rst_hwrite", 64'(HWRITE), 64'(0));
    check("rst_hsize", 64'(HSIZE), 64'(0));
    check("rst_hwdata", 64'(HWDATA), 64'(0));
    check("rst_hburst", 64'(HBURST), 64'(0));
    check_cap("rst_cap", 1'b0);

    addr_cmd(32'h0000_1000);
    data_cmd(1'b1, 2'd2, 1'b1, 32'hDEAD_BEEF, 0, 1'b0, 32'h0, 1'b0);
    data_cmd(1'b0, 2'd2, 1'b0, 32'h0, 0, 1'b0, 32'h1234_5678, 1'b0);

    addr_cmd(32'hFFFF_FFFE);
    data_cmd(1'b0, 2'd1, 1'b1, 32'h0, 0, 1'b0, 32'h0000_ABCD, 1'b0);
    data_cmd(1'b0, 2'd2, 1'b0, 32'h0, 3, 1'b0, 32'hCAFE_F00D, 1'b0);

    addr_cmd(32'h0000_2000);
    data_cmd(1'b1, 2'd2, 1'b1, 32'h5555_AAAA, 0, 1'b1, 32'h0, 1'b0);
    clr_status();
    data_cmd(1'b0, 2'd2, 1'b0, 32'h0, 0, 1'b0, 32'h0BAD_F00D, 1'b0);

    data_cmd(1'b1, 2'd0, 1'b1, 32'h0000_00A5, 0, 1'b0, 32'h0, 1'b1);
    data_cmd(1'b0, 2'd2, 1'b0, 32'h0, 0, 1'b0, 32'h7777_0001, 1'b0);

    data_cmd(1'b1, 2'd3, 1'b1, 32'h1111_2222, 0, 1'b0, 32'h0, 1'b0);
    cmd_valid  = 1'b1;
    cmd_regsel = 1'b1;
    cmd_size   = 2'd3;
    status_clr = 1'b1;
    @(negedge CLK);
    cmd_valid  = 1'b0;
    status_clr = 1'b0;
    m_err = 1'b1;
    m_ovr = 1'b0;
    check("setwins_htrans", 64'(HTRANS), 64'(0));
    check_cap("setwins_cap", 1'b0);
    clr_status();

    addr_cmd(32'h0000_1002);
    data_cmd(1'b1, 2'd2, 1'b0, 32'h0F0F_0F0F, 0, 1'b0, 32'h0, 1'b0);
    clr_status();

    for (int n = 0; n < 40; n++) begin
      logic [1:0] sz;
      if ($urandom_range(0, 3) == 0) addr_cmd($urandom);
      sz = ($urandom_range(0, 9) == 0) ? 2'd3
                                       : 2'($urandom_range(0, 2));
      data_cmd(1'($urandom), sz, 1'($urandom), $urandom,
               int'($urandom_range(0, 3)),
               ($urandom_range(0, 5) == 0),
               $urandom, ($urandom_range(0, 5) == 0));
      if ($urandom_range(0, 4) == 0) clr_status();
    end

    cmd_valid   = 1'b1;
    cmd_regsel  = 1'b1;
    cmd_size    = 2'd2;
    cmd_rw      = 1'b1;
    HREADY      = 1'b0;
    @(negedge CLK);
    cmd_valid = 1'b0;
    check("mid_htrans", 64'(HTRANS), 64'(2'b10));
    #2 nRST = 1'b0;
    #1;
    m_addr  = '0;
    m_rdata = '0;
    m_err   = 1'b0;
    m_ovr   = 1'b0;
    check("arst_htrans", 64'(HTRANS), 64'(0));
    check("arst_haddr", 64'(HADDR), 64'(0));
    check_cap("arst_cap", 1'b0);
    @(negedge CLK);
    nRST   = 1'b1;
    HREADY = 1'b1;
    @(negedge CLK);
    data_cmd(1'b0, 2'd2, 1'b1, 32'h0, 0, 1'b0, 32'h600D_CAFE, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
